// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for mem_port_arbiter: load/store size codes (funct3) and read-response owner states.
package mem_port_arbiter_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  localparam logic [1:0] RSP_IDLE = 2'd0;
  localparam logic [1:0] RSP_IF   = 2'd1;
  localparam logic [1:0] RSP_D    = 2'd2;

  // Undefined size codes behave as W, so they also require full word alignment.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      SIZE_B, SIZE_BU: return 1'b0;
      SIZE_H, SIZE_HU: return lo[0];
      default:         return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store byte strobes and data replication, plus load lane extract and extend.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] din,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = din[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? din[31:16] : din[15:0];
    be     = 4'hF;
    wdata  = din;
    rdata  = din;
    case (size)
      SIZE_B, SIZE_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{din[7:0]}};
        rdata = (size == SIZE_B) ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      end
      SIZE_H, SIZE_HU: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{din[15:0]}};
        rdata = (size == SIZE_H) ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between fetch and data; grants are combinational, read data returns one cycle later.
// A requester stalls while its grant is low; MEM_PORT_ARBITER_MISALIGN_CHK_EN adds misaligned-access suppression and d_misalign_o.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [2:0]        d_size_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
`ifdef MEM_PORT_ARBITER_MISALIGN_CHK_EN
  output logic              d_misalign_o,
`endif
  input  logic [31:0]       ram_rdata_i
);

  logic [1:0]  rsp_state;
  logic [1:0]  rsp_lo;
  logic [2:0]  rsp_size;
  logic        rsp_mis;
  logic [3:0]  starve_cnt;
  logic        fetch_pri;
  logic        d_mis;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] rd_ext;
  logic [31:0] wr_rdata_unused;
  logic [3:0]  rd_be_unused;
  logic [31:0] rd_wdata_unused;
  logic [1:0]  if_addr_lo_unused;

  assign if_addr_lo_unused = if_addr_i[1:0];

  // Data normally wins; a starved fetch takes the next contended cycle.
  assign fetch_pri = (starve_cnt == 4'(STARVE_MAX));
  assign if_gnt_o  = !rst && if_req_i && (!d_req_i || fetch_pri);
  assign d_gnt_o   = !rst && d_req_i && !if_gnt_o;

  mem_lane_align u_wr_align (
    .size    (d_size_i),
    .addr_lo (d_addr_i[1:0]),
    .din     (d_wdata_i),
    .be      (wr_be),
    .wdata   (wr_data),
    .rdata   (wr_rdata_unused)
  );

  mem_lane_align u_rd_align (
    .size    (rsp_size),
    .addr_lo (rsp_lo),
    .din     (ram_rdata_i),
    .be      (rd_be_unused),
    .wdata   (rd_wdata_unused),
    .rdata   (rd_ext)
  );

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = 32'd0;
    if (if_gnt_o) begin
      ram_en_o   = 1'b1;
      ram_be_o   = 4'hF;
      ram_addr_o = {if_addr_i[ADDR_W-1:2], 2'b00};
    end else if (d_gnt_o && !d_mis) begin
      ram_en_o    = 1'b1;
      ram_we_o    = d_we_i;
      ram_be_o    = d_we_i ? wr_be : 4'hF;
      ram_addr_o  = {d_addr_i[ADDR_W-1:2], 2'b00};
      ram_wdata_o = d_we_i ? wr_data : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_state  <= RSP_IDLE;
      rsp_lo     <= 2'b00;
      rsp_size   <= SIZE_W;
      starve_cnt <= 4'd0;
    end else begin
      if (if_gnt_o)                 rsp_state <= RSP_IF;
      else if (d_gnt_o && !d_we_i)  rsp_state <= RSP_D;
      else                          rsp_state <= RSP_IDLE;
      if (d_gnt_o && !d_we_i) begin
        rsp_lo   <= d_addr_i[1:0];
        rsp_size <= d_size_i;
      end
      if (!if_req_i || if_gnt_o)
        starve_cnt <= 4'd0;
      else if (starve_cnt != 4'(STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

`ifdef MEM_PORT_ARBITER_MISALIGN_CHK_EN
  logic misalign_q;

  assign d_mis        = is_misaligned(d_size_i, d_addr_i[1:0]);
  assign d_misalign_o = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_mis    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rsp_mis    <= d_gnt_o && !d_we_i && d_mis;
      misalign_q <= d_gnt_o && d_mis;
    end
  end
`else
  assign d_mis   = 1'b0;
  assign rsp_mis = 1'b0;
`endif

  // Responses come straight from the registered owner; a read in flight at reset is dropped.
  assign if_rvalid_o = !rst && (rsp_state == RSP_IF);
  assign d_rvalid_o  = !rst && (rsp_state == RSP_D);
  assign if_rdata_o  = if_rvalid_o ? ram_rdata_i : 32'd0;
  assign d_rdata_o   = (d_rvalid_o && !rsp_mis) ? rd_ext : 32'd0;

endmodule
